// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared snooping bus: grants one cache,
// broadcasts its coherence message, resolves dirty interventions and runs the memory access.
module snoop_bus_arbiter #(
    parameter int unsigned NCACHE       = 4,
    parameter int unsigned BLOCKADDRBIT = 14,
    parameter int unsigned BLOCKBYTE    = 4,
    parameter int unsigned WORDSIZE     = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NCACHE-1:0]                     busReq,
    input  logic [NCACHE-1:0]                     releaseBus,
    input  logic [4*NCACHE-1:0]                   reqAction,
    input  logic [BLOCKADDRBIT*NCACHE-1:0]        reqAddr,
    input  logic [BLOCKBYTE*WORDSIZE*NCACHE-1:0]  reqValue,
    input  logic [NCACHE-1:0]                     dirtyHit,
    output logic [NCACHE-1:0]                     busGrant,
    output logic [NCACHE-1:0]                     busAvailable,
    output logic [3:0]                            bcastAction,
    output logic [BLOCKADDRBIT-1:0]               bcastAddr,
    output logic [BLOCKBYTE*WORDSIZE-1:0]         bcastValue,
    output logic [2:0]                            bcastSrc,
    output logic                                  memReq,
    output logic                                  memWrite,
    output logic [BLOCKADDRBIT-1:0]               memAddr,
    output logic [BLOCKBYTE*WORDSIZE-1:0]         memWData,
    input  logic                                  memDone,
    input  logic [BLOCKBYTE*WORDSIZE-1:0]         memRData
);

    localparam int unsigned BW = BLOCKBYTE * WORDSIZE;
    localparam int unsigned OW = (NCACHE > 1) ? $clog2(NCACHE) : 1;

    localparam logic [3:0] MSG_NOTHING   = 4'd0;
    localparam logic [3:0] MSG_READMISS  = 4'd1;
    localparam logic [3:0] MSG_WRITEMISS = 4'd2;
    localparam logic [3:0] MSG_WRITEBACK = 4'd3;
    localparam logic [3:0] MSG_DATA      = 4'd4;

    typedef enum logic [2:0] {IDLE, GRANTED, BCAST, SNOOP, MEM, DONE, RELEASE} state_t;

    state_t                  state, stateNxt;
    logic [OW-1:0]           owner, ownerNxt, lastOwner, lastOwnerNxt;
    logic [3:0]              actQ, actNxt;
    logic [BLOCKADDRBIT-1:0] addrQ, addrNxt;
    logic [BW-1:0]           dataQ, dataNxt, doneData;

    logic [NCACHE-1:0]       busGrantNxt, busAvailableNxt;
    logic [3:0]              bcastActionNxt;
    logic [BLOCKADDRBIT-1:0] bcastAddrNxt, memAddrNxt;
    logic [BW-1:0]           bcastValueNxt, memWDataNxt;
    logic [2:0]              bcastSrcNxt;
    logic                    memReqNxt, memWriteNxt;

    logic [3:0]              actArr  [NCACHE];
    logic [BLOCKADDRBIT-1:0] addrArr [NCACHE];
    logic [BW-1:0]           valArr  [NCACHE];

    for (genvar g = 0; g < NCACHE; g++) begin : gUnpack
        assign actArr[g]  = reqAction[g*4 +: 4];
        assign addrArr[g] = reqAddr[g*BLOCKADDRBIT +: BLOCKADDRBIT];
        assign valArr[g]  = reqValue[g*BW +: BW];
    end

    // Round-robin pick: highest priority is lastOwner+1, lastOwner itself comes last
    logic              pickValid;
    logic [OW-1:0]     pick;
    int unsigned       idx;
    always_comb begin
        pickValid = 1'b0;
        pick      = '0;
        idx       = 0;
        for (int i = 0; i < int'(NCACHE); i++) begin
            idx = (32'(lastOwner) + NCACHE - 32'(i)) % NCACHE;
            if (busReq[OW'(idx)]) begin
                pick      = OW'(idx);
                pickValid = 1'b1;
            end
        end
    end

    // Lowest-index dirty holder other than the owner supplies the block
    logic [NCACHE-1:0] dirtyMasked;
    logic [OW-1:0]     dirtyIdx;
    always_comb begin
        dirtyMasked = dirtyHit & ~(NCACHE'(1) << owner);
        dirtyIdx    = '0;
        for (int i = int'(NCACHE) - 1; i >= 0; i--) begin
            if (dirtyMasked[OW'(i)]) dirtyIdx = OW'(i);
        end
    end

    always_comb begin
        stateNxt        = state;
        ownerNxt        = owner;
        lastOwnerNxt    = lastOwner;
        actNxt          = actQ;
        addrNxt         = addrQ;
        dataNxt         = dataQ;
        doneData        = memWrite ? dataQ : memRData;
        busGrantNxt     = busGrant;
        busAvailableNxt = '0;
        bcastActionNxt  = MSG_NOTHING;
        bcastAddrNxt    = '0;
        bcastValueNxt   = '0;
        bcastSrcNxt     = '0;
        memReqNxt       = 1'b0;
        memWriteNxt     = 1'b0;
        memAddrNxt      = '0;
        memWDataNxt     = '0;

        case (state)
            IDLE: begin
                if (pickValid) begin
                    ownerNxt    = pick;
                    busGrantNxt = NCACHE'(1) << pick;
                    stateNxt    = GRANTED;
                end
            end
            GRANTED: begin
                if (!busReq[owner]) begin
                    busGrantNxt  = '0;
                    lastOwnerNxt = owner;
                    stateNxt     = IDLE;
                end else if (actArr[owner] inside {MSG_READMISS, MSG_WRITEMISS, MSG_WRITEBACK}) begin
                    actNxt         = actArr[owner];
                    addrNxt        = addrArr[owner];
                    dataNxt        = valArr[owner];
                    bcastActionNxt = actArr[owner];
                    bcastAddrNxt   = addrArr[owner];
                    bcastValueNxt  = valArr[owner];
                    bcastSrcNxt    = 3'(owner);
                    stateNxt       = BCAST;
                end
            end
            BCAST: begin
                if (actQ == MSG_WRITEBACK) begin
                    memReqNxt   = 1'b1;
                    memWriteNxt = 1'b1;
                    memAddrNxt  = addrQ;
                    memWDataNxt = dataQ;
                    stateNxt    = MEM;
                end else begin
                    stateNxt = SNOOP;
                end
            end
            SNOOP: begin
                memReqNxt  = 1'b1;
                memAddrNxt = addrQ;
                if (|dirtyMasked) begin
                    memWriteNxt = 1'b1;
                    dataNxt     = valArr[dirtyIdx];
                    memWDataNxt = valArr[dirtyIdx];
                end
                stateNxt = MEM;
            end
            MEM: begin
                if (memDone) begin
                    dataNxt         = doneData;
                    busAvailableNxt = NCACHE'(1) << owner;
                    bcastSrcNxt     = 3'(owner);
                    if (actQ != MSG_WRITEBACK) begin
                        bcastActionNxt = MSG_DATA;
                        bcastAddrNxt   = addrQ;
                        bcastValueNxt  = doneData;
                    end
                    stateNxt = DONE;
                end else begin
                    memReqNxt   = 1'b1;
                    memWriteNxt = memWrite;
                    memAddrNxt  = memAddr;
                    memWDataNxt = memWData;
                end
            end
            DONE: begin
                stateNxt = RELEASE;
            end
            RELEASE: begin
                if (releaseBus[owner]) begin
                    busGrantNxt  = '0;
                    lastOwnerNxt = owner;
                    stateNxt     = IDLE;
                end
            end
            default: begin
                busGrantNxt = '0;
                stateNxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= '0;
            lastOwner    <= OW'(NCACHE - 1);
            actQ         <= MSG_NOTHING;
            addrQ        <= '0;
            dataQ        <= '0;
            busGrant     <= '0;
            busAvailable <= '0;
            bcastAction  <= MSG_NOTHING;
            bcastAddr    <= '0;
            bcastValue   <= '0;
            bcastSrc     <= '0;
            memReq       <= 1'b0;
            memWrite     <= 1'b0;
            memAddr      <= '0;
            memWData     <= '0;
        end else begin
            state        <= stateNxt;
            owner        <= ownerNxt;
            lastOwner    <= lastOwnerNxt;
            actQ         <= actNxt;
            addrQ        <= addrNxt;
            dataQ        <= dataNxt;
            busGrant     <= busGrantNxt;
            busAvailable <= busAvailableNxt;
            bcastAction  <= bcastActionNxt;
            bcastAddr    <= bcastAddrNxt;
            bcastValue   <= bcastValueNxt;
            bcastSrc     <= bcastSrcNxt;
            memReq       <= memReqNxt;
            memWrite     <= memWriteNxt;
            memAddr      <= memAddrNxt;
            memWData     <= memWDataNxt;
        end
    end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Round-robin arbiter and sequencer for the shared snooping bus between the private caches and main memory. It grants the bus to one requesting cache and broadcasts that cache's coherence message to all caches. It collects dirty-copy interventions, runs the memory transaction and returns block data to the requester. It sits between the `cache` instances and the memory controller.

## Interface
- `NCACHE`, 4, number of caches (2..8)
- `BLOCKADDRBIT`, 14, block address width
- `BLOCKBYTE`, 4, words per block
- `WORDSIZE`, 8, bits per word; block width `BW` = `BLOCKBYTE*WORDSIZE`
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `busReq`  in  NCACHE  per-cache bus request, level
- `releaseBus`  in  NCACHE  per-cache release, one-cycle pulse
- `reqAction`  in  4*NCACHE  per-cache message: 0 MSG_NOTHING, 1 MSG_READMISS, 2 MSG_WRITEMISS, 3 WRITEBACK
- `reqAddr`  in  BLOCKADDRBIT*NCACHE  per-cache block address
- `reqValue`  in  BW*NCACHE  per-cache block data (writeback or intervention data)
- `dirtyHit`  in  NCACHE  cache holds the broadcast block MODIFIED; valid in SNOOP only
- `busGrant`  out  NCACHE  one-hot grant
- `busAvailable`  out  NCACHE  one-cycle completion pulse to the owner
- `bcastAction`  out  4  broadcast message; 4 = MSG_DATA
- `bcastAddr`  out  BLOCKADDRBIT  broadcast block address
- `bcastValue`  out  BW  broadcast block data
- `bcastSrc`  out  3  index of the owner
- `memReq`  out  1  memory request, level until `memDone`
- `memWrite`  out  1  1 = write `memWData`, 0 = read
- `memAddr`  out  BLOCKADDRBIT  memory block address
- `memWData`  out  BW  memory write data
- `memDone`  in  1  one-cycle memory completion
- `memRData`  in  BW  read data, valid with `memDone`

## Operation
- States: IDLE, GRANTED, BCAST, SNOOP, MEM, DONE, RELEASE. Reset enters IDLE.
- Reset values: all outputs 0, `lastOwner` = NCACHE-1.
- IDLE: if any `busReq` is set, choose the first requester in order `lastOwner+1`, `+2`, … (mod NCACHE). Register `owner`, set `busGrant[owner]`, go to GRANTED.
- GRANTED:
  - If `busReq[owner]` is 0, drop the grant, set `lastOwner=owner`, go to IDLE.
  - Otherwise, if `reqAction[owner]` is not 0, latch action, address and value, then go to BCAST.
- BCAST (1 cycle):
  - Drive `bcastAction`/`bcastAddr`/`bcastValue`/`bcastSrc` from the latched values.
  - For WRITEBACK, go to MEM with write of the latched value.
  - For either miss, go to SNOOP.
- SNOOP (1 cycle):
  - Mask out `dirtyHit[owner]`.
  - If any bit remains, take the lowest index `d`, capture `reqValue[d]` as data and set `intervene`. MEM then does a write of that data.
  - Otherwise MEM does a read.
- MEM:
  - `memReq`=1 with `memWrite`, `memAddr` and `memWData` stable until `memDone`.
  - On `memDone`, drop `memReq` the same edge and go to DONE.
  - For a read, data = `memRData`.
- DONE (1 cycle):
  - `busAvailable[owner]`=1.
  - For a miss, `bcastAction`=4 with the latched address and data (intervention data or memory data).
  - For WRITEBACK, `bcastAction`=0.
  - Go to RELEASE.
- RELEASE: hold `busGrant`. When `releaseBus[owner]` is set, clear the grant, set `lastOwner=owner`, go to IDLE.
- Signal validity:
  - `bcastAction` is nonzero only in BCAST and DONE.
  - `bcastAddr`/`bcastValue` are don't-care when `bcastAction`=0.
  - `releaseBus`, `dirtyHit` and `reqAction` from non-owners are ignored outside their defined windows.
- An illegal `reqAction` (>3) in GRANTED is treated as MSG_NOTHING.

## Timing
- Grant latency: `busReq` sampled at edge N gives `busGrant` high after edge N; the IDLE→GRANTED transition is one cycle.
- Minimum read miss, with action presented in the first GRANTED cycle and `memDone` in the first MEM cycle: GRANTED, BCAST, SNOOP, MEM, DONE. That is 5 cycles from grant to the `busAvailable` pulse.
- WRITEBACK skips SNOOP: 4 cycles.
- `memDone` while not in MEM is ignored. `memDone` in the same cycle `memReq` first rises completes the transaction.
- Bus turnaround: RELEASE→IDLE costs one idle cycle. A new grant appears at the earliest 2 cycles after `releaseBus`.
- A released owner re-requesting immediately loses to any other pending requester (round-robin fairness).
- Reset low in any state, including MEM with `memReq` high, forces IDLE and all outputs to 0 at the next edge. A pending `memDone` is then ignored.

## Test plan
- Single read miss: cache 1 `busReq`, `reqAction`=1, addr 0x0123, no `dirtyHit`, `memDone` after 3 cycles with `memRData`=0xDEADBEEF. Expect BCAST 1/0x0123 with `bcastSrc`=1, then `memReq` read of 0x0123, then DONE with `bcastAction`=4 and value 0xDEADBEEF, and `busAvailable[1]` for exactly 1 cycle.
- Intervention: cache 0 write miss on 0x0040 while cache 2 asserts `dirtyHit` in SNOOP with `reqValue[2]`=0x11223344. Expect a memory write of 0x11223344 to 0x0040 and a DONE broadcast of data 0x11223344.
- Round-robin: `busReq`=4'b1111 held, with each owner releasing after DONE. Expect the grant order 0,1,2,3,0 starting from reset.
- Writeback: cache 3 action 3, addr 0x3FFF, value 0xCAFEF00D. Expect no SNOOP, a memory write, DONE with `bcastAction`=0, and `busAvailable[3]` set.
- Abandon: cache 2 granted, then drops `busReq` before any action. Expect `busGrant`=0 next cycle, no broadcast, no `memReq`, and the next grant starting at cache 3.
- Reset mid-MEM: pull `reset` low while `memReq`=1. Expect all outputs 0 next cycle, state IDLE, and a later `memDone` with no effect.
